// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - opcodes, controller states and settle-time lookup for alu_share_ctrl
package alu_share_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Requester identity as stored in last_grant / grantee
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] lat_of(
        input logic [2:0] op,
        input logic [3:0] lat_logic,
        input logic [3:0] lat_add,
        input logic [3:0] lat_mul,
        input logic [3:0] lat_cmp
    );
        logic [3:0] lat;
        case (op)
            OP_AND, OP_OR, OP_NOT:  lat = lat_logic;
            OP_ADD, OP_NEG, OP_SUB: lat = lat_add;
            OP_MUL:                 lat = lat_mul;
            default:                lat = lat_cmp;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin arbiter, bit 0 = A, bit 1 = B
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       gnt_valid
);

    always_comb begin
        grant = req;
        // On contention the requester that was not served last wins
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        gnt_valid = |req;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between requesters A and B with per-op settle time
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int LAT_LOGIC = 1,
    parameter int LAT_ADD   = 2,
    parameter int LAT_MUL   = 4,
    parameter int LAT_CMP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [2:0]  a_op,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [2:0]  b_op,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_choice,
    input  logic [31:0] alu_result,
    output logic        busy
);

    state_t      state, state_next;
    logic        last_grant;
    logic        grantee;
    logic [3:0]  cnt;
    logic [1:0]  grant;
    logic        gnt_valid;
    logic        accept;
    logic        rsp_hs;
    logic        sel_b;
    logic [2:0]  sel_op;
    logic [31:0] sel_x;
    logic [31:0] sel_y;

    rr_arb2 u_arb (
        .req        ({b_req_valid, a_req_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .gnt_valid  (gnt_valid)
    );

    // Ready is held low while reset is asserted even though state already reads IDLE
    assign a_req_ready = rst_n && (state == IDLE) && grant[0];
    assign b_req_ready = rst_n && (state == IDLE) && grant[1];
    assign accept      = rst_n && (state == IDLE) && gnt_valid;

    assign sel_b  = grant[1];
    assign sel_op = sel_b ? b_op : a_op;
    assign sel_x  = sel_b ? b_x  : a_x;
    assign sel_y  = sel_b ? b_y  : a_y;

    assign a_rsp_valid = (state == RESP) && (grantee == GNT_A);
    assign b_rsp_valid = (state == RESP) && (grantee == GNT_B);
    assign rsp_hs      = (state == RESP) && ((grantee == GNT_B) ? b_rsp_ready : a_rsp_ready);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_B;
            grantee    <= GNT_A;
            cnt        <= 4'd0;
            rsp_data   <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_choice <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grantee    <= sel_b;
                        alu_choice <= sel_op;
                        cnt        <= lat_of(sel_op, 4'(LAT_LOGIC), 4'(LAT_ADD),
                                             4'(LAT_MUL), 4'(LAT_CMP)) - 4'd1;
                        // MUL16 multiplies the low halves only; unary ops see a zero second operand
                        case (sel_op)
                            OP_MUL: begin
                                alu_in1 <= {16'b0, sel_x[15:0]};
                                alu_in2 <= {16'b0, sel_y[15:0]};
                            end
                            OP_NOT, OP_NEG: begin
                                alu_in1 <= sel_x;
                                alu_in2 <= '0;
                            end
                            default: begin
                                alu_in1 <= sel_x;
                                alu_in2 <= sel_y;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data <= alu_result;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= grantee;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl with a behavioural ALU
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic        a_req_ready, b_req_ready;
    logic [2:0]  a_op = '0, b_op = '0;
    logic [31:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
    logic        a_rsp_valid, b_rsp_valid;
    logic        a_rsp_ready = 1'b1, b_rsp_ready = 1'b1;
    logic [31:0] rsp_data, alu_in1, alu_in2, alu_result;
    logic [2:0]  alu_choice;
    logic        busy;

    typedef struct {
        bit          who;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    bit   exp_grant[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_wait = 0;
    bit   seen = 0;
    exp_t cur;

    alu_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .rsp_data(rsp_data), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_choice(alu_choice),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_result = '0;
        case (alu_choice)
            3'd0: alu_result = alu_in1 & alu_in2;
            3'd1: alu_result = alu_in1 | alu_in2;
            3'd2: alu_result = alu_in1 + alu_in2;
            3'd3: alu_result = ~alu_in1;
            3'd4: alu_result = -alu_in1;
            3'd5: alu_result = alu_in1 - alu_in2;
            3'd6: alu_result = alu_in1 * alu_in2;
            default: alu_result = {29'b0, alu_in1 > alu_in2, alu_in1 < alu_in2, alu_in1 == alu_in2};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Monitor: pops the expected response on the first valid cycle, checks data until handshake
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (a_rsp_valid && b_rsp_valid) chk("rsp_valid_exclusive", 32'd1, 32'd0);
            if (a_rsp_valid || b_rsp_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'(b_rsp_valid), 32'hFFFF_FFFF);
                    end else begin
                        cur = sb.pop_front();
                        seen = 1;
                        chk("rsp_requester", 32'(b_rsp_valid), 32'(cur.who));
                        chk("rsp_latency_cycle", cyc, cur.due);
                    end
                end
                if (seen) begin
                    chk("rsp_data", rsp_data, cur.data);
                    if (a_rsp_valid ? a_rsp_ready : b_rsp_ready) seen = 0;
                end
            end
        end
    end

    task automatic issue(input bit who, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_d, input int lat,
                         input bit push);
        int n;
        bit eg;
        @(negedge clk);
        if (!who) begin
            a_req_valid = 1; a_op = op; a_x = x; a_y = y;
        end else begin
            b_req_valid = 1; b_op = op; b_x = x; b_y = y;
        end
        #1;
        n = 0;
        while (!(who ? b_req_ready : a_req_ready) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        last_wait = n;
        if (n >= 200) begin
            n_checks++;
            $display("FAIL accept_timeout: requester %0d not accepted, required within 200 cycles", who);
        end else begin
            if (exp_grant.size() > 0) begin
                eg = exp_grant.pop_front();
                chk("grant_order", 32'(who), 32'(eg));
            end
            if (push) sb.push_back('{who, exp_d, cyc + 1 + lat});
        end
        @(posedge clk); #1;
        if (!who) a_req_valid = 0; else b_req_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still %0b, required 0 within 100 cycles", busy);
        end
    endtask

    task automatic apply_reset();
        rst_n = 0;
        a_req_valid = 0; b_req_valid = 0;
        a_rsp_ready = 1; b_rsp_ready = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'd0);
        chk({tag, "_a_req_ready"}, 32'(a_req_ready), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_in2"}, alu_in2, 32'd0);
        chk({tag, "_alu_choice"}, 32'(alu_choice), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        apply_reset();

        // Single ADD from A
        exp_grant.push_back(0);
        issue(0, 3'd2, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 2, 1);
        chk("a_ready_same_cycle", last_wait, 32'd0);
        wait_idle();

        // Contention from reset: strict alternation A, B, A, B
        apply_reset();
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            begin
                issue(0, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 1);
                issue(0, 3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2, 1);
            end
            begin
                issue(1, 3'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1, 1);
                issue(1, 3'd5, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 2, 1);
            end
        join
        wait_idle();

        // Operand shaping: MUL16, NOT, NEG
        issue(0, 3'd6, 32'hABCD_0012, 32'hFFFF_0003, 32'h0000_0036, 4, 1);
        chk("mul_alu_in1", alu_in1, 32'h0000_0012);
        chk("mul_alu_in2", alu_in2, 32'h0000_0003);
        chk("mul_alu_choice", 32'(alu_choice), 32'd6);
        chk("mul_busy", 32'(busy), 32'd1);
        wait_idle();
        issue(1, 3'd3, 32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0, 1, 1);
        chk("not_alu_in2", alu_in2, 32'd0);
        wait_idle();
        issue(0, 3'd4, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 1);
        chk("neg_alu_in2", alu_in2, 32'd0);
        wait_idle();

        // Response backpressure on B's CMP while A waits
        b_rsp_ready = 0;
        issue(1, 3'd7, 32'd5, 32'd9, 32'h0000_0002, 2, 1);
        fork
            issue(0, 3'd2, 32'd1, 32'd2, 32'd3, 2, 1);
            begin
                int n = 0;
                while (!b_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
                chk("bp_rsp_arrived", 32'(b_rsp_valid), 32'd1);
                repeat (6) begin
                    @(negedge clk); #1;
                    chk("bp_b_rsp_valid_held", 32'(b_rsp_valid), 32'd1);
                    chk("bp_rsp_data_held", rsp_data, 32'h0000_0002);
                    chk("bp_a_req_ready_low", 32'(a_req_ready), 32'd0);
                end
                b_rsp_ready = 1;
                @(negedge clk); #1;
                chk("bp_a_ready_after_hs", 32'(a_req_ready), 32'd1);
            end
        join
        wait_idle();

        // Reset during WAIT of an ADD: no response, A regains priority
        issue(0, 3'd2, 32'd10, 32'd20, 32'd30, 2, 0);
        rst_n = 0;
        #1;
        chk_all_zero("midop_reset");
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("post_reset_no_rsp", 32'(a_rsp_valid), 32'd0);
        chk("post_reset_idle", 32'(busy), 32'd0);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            issue(0, 3'd1, 32'h0000_0004, 32'h0000_0001, 32'h0000_0005, 1, 1);
            issue(1, 3'd0, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 1, 1);
        join
        wait_idle();
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
